// File: rtl/uart_rx_ctrl_fsm.sv
// UART receive frame sequencer: start detect, oversample/bit counting, checker strobes.
// Define UART_RX_FRAME_ERR_EN to add the frm_err output for rejected frames.
module uart_rx_ctrl_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               deser_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               rst_check,
`ifdef UART_RX_FRAME_ERR_EN
    output logic               data_valid,
    output logic               frm_err
`else
    output logic               data_valid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_CHECK  = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [PRESC_W-1:0] edge_r, edge_s, edge_inc_s;
    logic [PRESC_W-1:0] presc_r, presc_s;
    logic [PRESC_W-1:0] chk_cur_s, last_cur_s, chk_nxt_s;
    logic [3:0]         bit_r, bit_s, bit_inc_s;
    logic               par_en_r, par_en_s, wrap_s;
    logic               samp_r, samp_s, strt_r, strt_s, deser_r, deser_s;
    logic               par_r, par_s, stp_r, stp_s, rstc_r, rstc_s;
    logic               dv_s, fe_s;

    // Timing points of the frame in flight come from the latched prescale.
    assign chk_cur_s  = (presc_r >> 1) + PRESC_W'(2);
    assign last_cur_s = presc_r - PRESC_W'(1);
    assign chk_nxt_s  = (presc_s >> 1) + PRESC_W'(2);
    assign wrap_s     = (edge_r == last_cur_s);
    assign edge_inc_s = wrap_s ? {PRESC_W{1'b0}} : (edge_r + PRESC_W'(1));
    assign bit_inc_s  = wrap_s ? (bit_r + 4'd1) : bit_r;

    // State, counter, latched frame configuration and registered strobe outputs.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_r  <= S_IDLE;
            edge_r   <= {PRESC_W{1'b0}};
            bit_r    <= 4'd0;
            presc_r  <= {PRESC_W{1'b0}};
            par_en_r <= 1'b0;
            samp_r   <= 1'b0;
            strt_r   <= 1'b0;
            deser_r  <= 1'b0;
            par_r    <= 1'b0;
            stp_r    <= 1'b0;
            rstc_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            edge_r   <= edge_s;
            bit_r    <= bit_s;
            presc_r  <= presc_s;
            par_en_r <= par_en_s;
            samp_r   <= samp_s;
            strt_r   <= strt_s;
            deser_r  <= deser_s;
            par_r    <= par_s;
            stp_r    <= stp_s;
            rstc_r   <= rstc_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_s  = state_r;
        edge_s   = edge_inc_s;
        bit_s    = bit_inc_s;
        presc_s  = presc_r;
        par_en_s = par_en_r;
        case (state_r)
            S_IDLE: begin
                if (!rx_in) begin
                    state_s  = S_START;
                    edge_s   = PRESC_W'(1);
                    bit_s    = 4'd0;
                    presc_s  = prescale;
                    par_en_s = par_en;
                end else begin
                    edge_s = {PRESC_W{1'b0}};
                    bit_s  = 4'd0;
                end
            end
            S_START: begin
                if (wrap_s && strt_glitch) begin
                    state_s = S_IDLE;
                    bit_s   = 4'd0;
                end else if (wrap_s) begin
                    state_s = S_DATA;
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (wrap_s && (bit_r == 4'(DATA_WIDTH))) begin
                    state_s = par_en_r ? S_PARITY : S_STOP;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_PARITY: begin
                if (wrap_s) begin
                    state_s = S_STOP;
                end else begin
                    state_s = S_PARITY;
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a following start edge is never missed.
                if (edge_r == chk_cur_s) begin
                    state_s = S_CHECK;
                end else begin
                    state_s = S_STOP;
                end
            end
            S_CHECK: begin
                state_s = S_IDLE;
                edge_s  = {PRESC_W{1'b0}};
                bit_s   = 4'd0;
            end
            default: begin
                state_s = S_IDLE;
                edge_s  = {PRESC_W{1'b0}};
                bit_s   = 4'd0;
            end
        endcase
    end

    // Output decode: strobes are precomputed for the next cycle and registered;
    // the frame verdict is gated in CHECK because the checker answers only then.
    always_comb begin
        samp_s  = (state_s != S_IDLE);
        strt_s  = (state_s == S_START)  && (edge_s == chk_nxt_s);
        deser_s = (state_s == S_DATA)   && (edge_s == chk_nxt_s);
        par_s   = (state_s == S_PARITY) && (edge_s == chk_nxt_s);
        stp_s   = (state_s == S_STOP)   && (edge_s == chk_nxt_s);
        rstc_s  = (state_r == S_IDLE)   && (state_s == S_START);
        if (state_r == S_CHECK) begin
            dv_s = ~stp_err & ~(par_en_r & par_err);
            fe_s = stp_err | (par_en_r & par_err);
        end else begin
            dv_s = 1'b0;
            fe_s = 1'b0;
        end
    end

    assign edge_cnt    = edge_r;
    assign bit_cnt     = bit_r;
    assign dat_samp_en = samp_r;
    assign strt_chk_en = strt_r;
    assign deser_en    = deser_r;
    assign par_chk_en  = par_r;
    assign stp_chk_en  = stp_r;
    assign rst_check   = rstc_r;
    assign data_valid  = dv_s;
`ifdef UART_RX_FRAME_ERR_EN
    assign frm_err     = fe_s;
`else
    logic unused_fe_s;
    assign unused_fe_s = fe_s;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl_fsm.sv
// Scoreboard bench for uart_rx_ctrl_fsm: randomized frames vs. a frame-level model.
module tb_uart_rx_ctrl_fsm;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          RST = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          par_en = 1'b0;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
    logic          rst_check, data_valid;
`ifdef UART_RX_FRAME_ERR_EN
    logic          frm_err;
`endif

    uart_rx_ctrl_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .clk(clk), .RST(RST), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .rst_check(rst_check),
`ifdef UART_RX_FRAME_ERR_EN
        .data_valid(data_valid), .frm_err(frm_err)
`else
        .data_valid(data_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        bit         pen;
        logic [7:0] data;
        bit         glitch;
        bit         valid;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   cfg_glitch = 1'b0, cfg_perr = 1'b0, cfg_serr = 1'b0, cfg_pen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int pick_p();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 8 : ((r == 1) ? 16 : 32);
    endfunction

    function automatic int all_outputs();
        int v;
        v = int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                  stp_chk_en, rst_check, data_valid});
`ifdef UART_RX_FRAME_ERR_EN
        v = v | int'(frm_err);
`endif
        return v;
    endfunction

    // Drives one frame from a negedge; pushes the model's verdict first.
    task automatic send_frame(input int p, input bit pen, input logic [7:0] d,
                              input bit glitch, input bit perr, input bit serr, input int gap);
        exp_t e;
        e.p = p; e.pen = pen; e.data = d; e.glitch = glitch;
        e.valid = !glitch && !serr && !(pen && perr);
        sb_q.push_back(e);
        cfg_glitch = glitch; cfg_perr = perr; cfg_serr = serr; cfg_pen = pen;
        prescale = 6'(p);
        par_en = pen;
        rx_in = 1'b0;
        @(negedge clk);
        prescale = 6'(pick_p());
        par_en = 1'($urandom_range(0, 1));
        if (glitch) begin
            repeat (2) @(negedge clk);
            rx_in = 1'b1;
            repeat (p - 3) @(negedge clk);
        end else begin
            repeat (p - 1) @(negedge clk);
            for (int i = 0; i < DW; i++) begin
                rx_in = d[i];
                repeat (p) @(negedge clk);
            end
            if (pen) begin
                rx_in = ^d;
                repeat (p) @(negedge clk);
            end
            rx_in = 1'b1;
            repeat (p) @(negedge clk);
        end
        repeat (gap) @(negedge clk);
    endtask

    // Checker stand-ins: sticky result flags answering the strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (!RST) begin
                strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
            end else begin
                if (rst_check) begin
                    strt_glitch = 1'b0; stp_err = 1'b0;
                    par_err = cfg_pen ? 1'b0 : cfg_perr;
                end
                if (strt_chk_en) strt_glitch = cfg_glitch;
                if (par_chk_en)  par_err = cfg_perr;
                if (stp_chk_en)  stp_err = cfg_serr;
            end
        end
    end

    // Monitor: gathers one frame's activity, then compares it with the scoreboard.
    initial begin
        bit         prev_busy;
        int         blen, n_strt, n_deser, n_par, n_stp, n_rst, n_dv, n_fe, excl_bad;
        int         pos_q[$];
        int         dbit_q[$];
        logic [7:0] cap;
        exp_t       e;
        int         chk, exp_len, bad;
        prev_busy = 1'b0;
        blen = 0; n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0;
        n_rst = 0; n_dv = 0; n_fe = 0; excl_bad = 0; cap = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!RST) begin
                prev_busy = 1'b0;
                blen = 0; n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0;
                n_rst = 0; n_dv = 0; n_fe = 0; excl_bad = 0; cap = 8'h00;
                pos_q.delete(); dbit_q.delete();
            end else begin
                if (dat_samp_en) blen++;
                if ((int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en)) > 1)
                    excl_bad++;
                if (strt_chk_en) begin n_strt++; pos_q.push_back(int'(edge_cnt)); end
                if (par_chk_en)  begin n_par++;  pos_q.push_back(int'(edge_cnt)); end
                if (stp_chk_en)  begin n_stp++;  pos_q.push_back(int'(edge_cnt)); end
                if (deser_en) begin
                    if (n_deser < DW) cap[n_deser] = rx_in;
                    n_deser++;
                    pos_q.push_back(int'(edge_cnt));
                    dbit_q.push_back(int'(bit_cnt));
                end
                n_rst += int'(rst_check);
                n_dv  += int'(data_valid);
`ifdef UART_RX_FRAME_ERR_EN
                n_fe  += int'(frm_err);
`endif
                if (!dat_samp_en && prev_busy) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk = (e.p / 2) + 2;
                        exp_len = e.glitch ? (e.p - 1)
                                           : ((9 + int'(e.pen)) * e.p - 1 + chk + 2);
                        check("busy_len", blen, exp_len);
                        check("strt_chk_cnt", n_strt, 1);
                        check("deser_cnt", n_deser, e.glitch ? 0 : DW);
                        check("par_chk_cnt", n_par, (!e.glitch && e.pen) ? 1 : 0);
                        check("stp_chk_cnt", n_stp, e.glitch ? 0 : 1);
                        check("rst_check_cnt", n_rst, 1);
                        check("data_valid_cnt", n_dv, e.valid ? 1 : 0);
                        check("strobe_overlap", excl_bad, 0);
                        bad = 0;
                        foreach (pos_q[i]) if (pos_q[i] != chk) bad++;
                        check("strobe_edge_pos", bad, 0);
                        bad = 0;
                        foreach (dbit_q[i]) if (dbit_q[i] != i + 1) bad++;
                        check("deser_bit_idx", bad, 0);
                        if (!e.glitch) check("data_bits", int'(cap), int'(e.data));
                        check("idle_edge_cnt", int'(edge_cnt), 0);
                        check("idle_bit_cnt", int'(bit_cnt), 0);
`ifdef UART_RX_FRAME_ERR_EN
                        check("frm_err_cnt", n_fe, (!e.glitch && !e.valid) ? 1 : 0);
`endif
                    end
                    blen = 0; n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0;
                    n_rst = 0; n_dv = 0; n_fe = 0; excl_bad = 0; cap = 8'h00;
                    pos_q.delete(); dbit_q.delete();
                end
                prev_busy = dat_samp_en;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, a mid-frame reset, then random frames.
    initial begin
        bit hit;
        RST = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        RST = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 2);
        send_frame(16, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 2);
        send_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2);

        cfg_glitch = 1'b0; cfg_perr = 1'b0; cfg_serr = 1'b0; cfg_pen = 1'b0;
        prescale = 6'd16; par_en = 1'b0; rx_in = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (dat_samp_en && (bit_cnt == 4'd4)) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_wait_bit4", int'(hit), 1);
        @(negedge clk);
        RST = 1'b0;
        rx_in = 1'b1;
        #1;
        check("rst_mid_outputs", all_outputs(), 0);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);

        send_frame(32, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        send_frame(32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3);
        send_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1, 2);
        send_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0, 1);

        for (int n = 0; n < 40; n++) begin
            send_frame(pick_p(), 1'($urandom_range(0, 1)), 8'($urandom),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        repeat (40) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
